// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over a byte stream, writes it
// into the instruction memory one 32-bit word at a time and holds the CPU
// core in reset until a frame with a matching checksum has been loaded.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for sync byte 0xA5, core released
// CNT_LO  | expecting low byte of word count
// CNT_HI  | expecting high byte of word count, range check on receipt
// DATA    | collecting payload bytes, one imem write per four bytes
// CSUM    | expecting checksum byte
// DONE    | image loaded and verified, core released
// ERR     | frame aborted (bad count, bad checksum, timeout), core held
module imem_loader #(
    parameter int N           = 2048,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_cpu_rst_n
);

    localparam int AW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_count;
    logic [AW-1:0]   r_word_idx;
    logic [1:0]      r_lane;
    logic [7:0]      r_csum;
    logic [23:0]     r_word;
    logic [TW-1:0]   r_idle;

    logic            w_in_frame;
    logic            w_timeout;
    logic            w_last_word;
    logic [15:0]     w_cnt_full;
    logic            w_cnt_bad;

    assign w_in_frame  = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) ||
                         (r_state == S_DATA)   || (r_state == S_CSUM);
    // A byte arriving on the expiring cycle takes priority over the timeout.
    assign w_timeout   = w_in_frame && !i_rx_valid && (r_idle == TW'(TIMEOUT_CYC - 1));
    assign w_last_word = ({{(16-AW){1'b0}}, r_word_idx} == (r_count - 16'd1));
    assign w_cnt_full  = {i_rx_data, r_count[7:0]};
    assign w_cnt_bad   = (w_cnt_full == 16'd0) || (32'(w_cnt_full) > 32'(N));

    // Next-state selection; all transitions are byte-driven except timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR:
                if (i_rx_valid && i_rx_data == SYNC) w_next = S_CNT_LO;
            S_CNT_LO:
                if (i_rx_valid) w_next = S_CNT_HI;
            S_CNT_HI:
                if (i_rx_valid) w_next = w_cnt_bad ? S_ERR : S_DATA;
            S_DATA:
                if (i_rx_valid && r_lane == 2'd3 && w_last_word) w_next = S_CSUM;
            S_CSUM:
                if (i_rx_valid) w_next = (i_rx_data == r_csum) ? S_DONE : S_ERR;
            default:
                w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_ERR;
    end

    // State, datapath registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_word_idx  <= '0;
            r_lane      <= '0;
            r_csum      <= '0;
            r_word      <= '0;
            r_idle      <= '0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_cpu_rst_n <= 1'b1;
        end else begin
            r_state     <= w_next;
            o_wr_en     <= 1'b0;
            o_busy      <= (w_next == S_CNT_LO) || (w_next == S_CNT_HI) ||
                           (w_next == S_DATA)   || (w_next == S_CSUM);
            o_done      <= (w_next == S_DONE);
            o_err       <= (w_next == S_ERR);
            o_cpu_rst_n <= (w_next == S_IDLE) || (w_next == S_DONE);

            if (w_in_frame && !i_rx_valid) r_idle <= r_idle + TW'(1);
            else                           r_idle <= '0;

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_rx_valid && i_rx_data == SYNC) begin
                        r_word_idx <= '0;
                        r_lane     <= '0;
                        r_csum     <= '0;
                    end
                end
                S_CNT_LO: if (i_rx_valid) r_count[7:0]  <= i_rx_data;
                S_CNT_HI: if (i_rx_valid) r_count[15:8] <= i_rx_data;
                S_DATA: begin
                    if (i_rx_valid) begin
                        r_csum <= r_csum + i_rx_data;
                        if (r_lane == 2'd3) begin
                            o_wr_en    <= 1'b1;
                            o_wr_addr  <= {{(30-AW){1'b0}}, r_word_idx, 2'b00};
                            o_wr_data  <= {i_rx_data, r_word};
                            r_word_idx <= r_word_idx + AW'(1);
                            r_lane     <= 2'd0;
                        end else begin
                            // Shift in from the top so lane 0 ends up in bits [7:0].
                            r_word <= {i_rx_data, r_word[23:8]};
                            r_lane <= r_lane + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
